// File: rtl/somador_serial.sv
// ---------------------------------------------------------------------------
// somador_serial
//   Bit-serial adder. A start request latches both operands and the carry-in,
//   then one bit per clock is summed LSB first through a single full adder
//   with a registered carry. After WIDTH run cycles the result is presented
//   for one cycle with done high, and it stays on the outputs until the next
//   accepted start.
//
// Optional feature:
//   SOMADOR_SUB_EN - when defined, adds the 'sub' input. With sub=1 the block
//                    computes a - b as a + ~b + 1. In that mode cin is ignored
//                    and cout=1 means no borrow.
//
// Ports:
//   clk      in   1      clock, rising edge
//   rst_n    in   1      asynchronous active-low reset
//   start    in   1      begin an operation (accepted in IDLE or DONE only)
//   a, b     in   WIDTH  operands, captured on acceptance
//   cin      in   1      carry-in, captured on acceptance
//   sub      in   1      subtract select (SOMADOR_SUB_EN builds only)
//   busy     out  1      high while bits are being processed (RUN)
//   done     out  1      one-cycle pulse, result valid
//   s        out  WIDTH  sum
//   cout     out  1      carry out of the MSB
//   overflow out  1      signed overflow (carry into MSB ^ carry out of MSB)
// ---------------------------------------------------------------------------
module somador_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SOMADOR_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             sumBit;
  logic             carryNext;

  // All state lives here. Reset clears everything at once, so aborting a
  // RUN leaves no trace and no done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath. IDLE and DONE share the acceptance path, so a
  // start held high in DONE chains straight into the next RUN with no gap.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    sumBit    = 1'b0;
    carryNext = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
`ifdef SOMADOR_SUB_EN
          // Subtraction reuses the adder: invert b and force carry-in to 1.
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
`else
          b_d     = b;
          carry_d = cin;
`endif
          cnt_d   = '0;
          s_d     = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      RUN: begin
        sumBit        = a_q[cnt_q] ^ b_q[cnt_q] ^ carry_q;
        carryNext     = (a_q[cnt_q] & b_q[cnt_q]) |
                        (a_q[cnt_q] & carry_q)    |
                        (b_q[cnt_q] & carry_q);
        s_d[cnt_q]    = sumBit;
        carry_d       = carryNext;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // On the MSB, carry_q is the carry into the MSB and carryNext the
          // carry out of it; their XOR is the signed overflow.
          state_d = DONE;
          cout_d  = carryNext;
          ovf_d   = carry_q ^ carryNext;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign s        = s_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_somador_serial.sv
// ---------------------------------------------------------------------------
// tb_somador_serial
//   Scoreboard bench for somador_serial. The driver pushes the expected result
//   of every operation into a queue when it issues start. An independent
//   monitor pops one entry on every done pulse and compares it. Expected
//   values come from plain integer arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_somador_serial;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SOMADOR_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             overflow;

  exp_t expQ[$];
  exp_t lastExp;
  int   checks = 0;
  int   fails  = 0;

  somador_serial #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef SOMADOR_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .s        (s),
    .cout     (cout),
    .overflow (overflow)
  );

  // 100 MHz free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: integer sum in WIDTH+1 bits. Signed overflow means
  // both addends share a sign that the result does not have.
  function automatic exp_t model(input logic [WIDTH-1:0] opA,
                                 input logic [WIDTH-1:0] opB,
                                 input logic opCin, input logic opSub);
    exp_t           r;
    logic [WIDTH:0] total;
    logic [WIDTH-1:0] addB;
    logic           addC;
    addB   = opSub ? ~opB : opB;
    addC   = opSub ? 1'b1 : opCin;
    total  = {1'b0, opA} + {1'b0, addB} + (WIDTH + 1)'(addC);
    r.s    = total[WIDTH-1:0];
    r.cout = total[WIDTH];
    r.ovf  = (opA[WIDTH-1] == addB[WIDTH-1]) && (total[WIDTH-1] != opA[WIDTH-1]);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: whenever the DUT flags a result, compare it with the oldest
  // outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (expQ.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpectedDone: got done=1, expected no pending op at %0t", $time);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("sum",      64'(s),        64'(e.s));
        checkOutput("cout",     64'(cout),     64'(e.cout));
        checkOutput("overflow", 64'(overflow), 64'(e.ovf));
      end
    end
  end

  // Issues one operation from a negedge inside IDLE or DONE. It scrambles
  // inputs and pulses start during RUN, checks busy/done timing, and returns
  // at the negedge of the DONE cycle with start low.
  task automatic applyStimulus(input logic [WIDTH-1:0] opA,
                               input logic [WIDTH-1:0] opB,
                               input logic opCin, input logic opSub);
    exp_t e;
    a     = opA;
    b     = opB;
    cin   = opCin;
`ifdef SOMADOR_SUB_EN
    sub   = opSub;
`endif
    start = 1'b1;
    e = model(opA, opB, opCin, opSub);
    expQ.push_back(e);
    lastExp = e;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= WIDTH + 1; k++) begin
      @(negedge clk);
      if (k <= WIDTH) begin
        checkOutput("busyInRun", 64'(busy), 64'(1));
        checkOutput("doneInRun", 64'(done), 64'(0));
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cin   = 1'($urandom);
`ifdef SOMADOR_SUB_EN
        sub   = 1'($urandom);
`endif
        start = 1'($urandom_range(0, 1));
      end else begin
        checkOutput("doneAtLatency", 64'(done), 64'(1));
        checkOutput("busyInDone",    64'(busy), 64'(0));
        start = 1'b0;
      end
    end
  endtask

  // One idle cycle after DONE: result must stay on the outputs.
  task automatic idleCycle();
    @(negedge clk);
    checkOutput("doneIdle", 64'(done), 64'(0));
    checkOutput("busyIdle", 64'(busy), 64'(0));
    checkOutput("sumHeld",  64'(s),    64'(lastExp.s));
    checkOutput("coutHeld", 64'(cout), 64'(lastExp.cout));
    checkOutput("ovfHeld",  64'(overflow), 64'(lastExp.ovf));
  endtask

  // Starts an operation and pulls reset low during its 4th RUN cycle.
  task automatic abortWithReset();
    a     = 8'hAA;
    b     = 8'h57;
    cin   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rstBusy", 64'(busy),     64'(0));
    checkOutput("rstDone", 64'(done),     64'(0));
    checkOutput("rstSum",  64'(s),        64'(0));
    checkOutput("rstCout", 64'(cout),     64'(0));
    checkOutput("rstOvf",  64'(overflow), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < WIDTH + 3; k++) begin
      @(negedge clk);
      checkOutput("noDoneAfterAbort", 64'(done), 64'(0));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
`ifdef SOMADOR_SUB_EN
    sub   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("resetBusy", 64'(busy),     64'(0));
    checkOutput("resetDone", 64'(done),     64'(0));
    checkOutput("resetSum",  64'(s),        64'(0));
    checkOutput("resetCout", 64'(cout),     64'(0));
    checkOutput("resetOvf",  64'(overflow), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    applyStimulus(8'h3C, 8'h05, 1'b0, 1'b0);
    idleCycle();
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0);
    idleCycle();
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0);
    idleCycle();
    applyStimulus(8'h80, 8'h80, 1'b0, 1'b0);
    idleCycle();
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    idleCycle();

    // Back-to-back: start re-asserted in the DONE cycle
    applyStimulus(8'h10, 8'h20, 1'b0, 1'b0);
    applyStimulus(8'h01, 8'h01, 1'b0, 1'b0);
    idleCycle();

    // Reset mid-RUN, then a fresh operation
    abortWithReset();
    applyStimulus(8'h02, 8'h03, 1'b0, 1'b0);
    idleCycle();

`ifdef SOMADOR_SUB_EN
    applyStimulus(8'h05, 8'h07, 1'b1, 1'b1);
    idleCycle();
    applyStimulus(8'h07, 8'h05, 1'b0, 1'b1);
    idleCycle();
`endif

    // Randomized operations, randomly chained or separated
    for (int i = 0; i < 24; i++) begin
      logic opSub;
`ifdef SOMADOR_SUB_EN
      opSub = 1'($urandom);
`else
      opSub = 1'b0;
`endif
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), opSub);
      if ($urandom_range(0, 1) == 1) idleCycle();
    end
    idleCycle();

    repeat (3) @(negedge clk);
    checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/somador_serial.md
SOMADOR_SERIAL -- requirements
Module: somador_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal range 2..64).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 SHALL have port a  input  WIDTH  first operand; captured only when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  second operand; captured only when start is accepted.
REQ-007 SHALL have port cin  input  1  carry-in; captured only when start is accepted.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse marking valid results.
REQ-010 SHALL have port s  output  WIDTH  sum result.
REQ-011 SHALL have port cout  output  1  final carry-out.
REQ-012 SHALL have port overflow  output  1  two's-complement signed overflow of the result.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL accept start only in IDLE or DONE; start in RUN SHALL be ignored, with no effect on the in-flight operation.
REQ-015 On acceptance, SHALL latch a, b, cin, clear the bit counter and s, and enter RUN.
REQ-016 In RUN, SHALL process one bit per cycle, LSB first, using a 1-bit full adder (sum = a^b^c, carry = majority(a,b,c)) with a registered carry.
REQ-017 SHALL write bit i of s on the i-th RUN cycle (i = 0..WIDTH-1).
REQ-018 SHALL leave RUN for DONE exactly WIDTH cycles after acceptance; total latency start-edge to done-high = WIDTH cycles.
REQ-019 done SHALL be high for exactly the one cycle spent in DONE; busy SHALL be high exactly in RUN.
REQ-020 In DONE, s, cout and overflow SHALL be valid and held unchanged until the next accepted start.
REQ-021 overflow SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-022 DONE SHALL go to IDLE when start is low, or directly to RUN when start is high (back-to-back, no idle cycle).
REQ-023 Changes on a, b, cin during RUN SHALL NOT affect the result.
REQ-024 Result SHALL equal (a + b + cin) mod 2^WIDTH, with cout as bit WIDTH, for all operand values, including all-ones + all-ones + 1.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, busy=0, done=0, s=0, cout=0, overflow=0, carry and counter to 0, regardless of clk.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-027 Macro SOMADOR_SUB_EN SHALL control subtract mode.
REQ-028 With SOMADOR_SUB_EN defined, SHALL add input port sub (1 bit), captured at start acceptance; sub=1 SHALL compute a - b as a + ~b + 1 with cin ignored, and cout=1 meaning no borrow; sub=0 SHALL behave as the plain adder.
REQ-029 Without SOMADOR_SUB_EN, the sub port and its logic SHALL be absent, and the block SHALL behave as the adder only.

Verification
REQ-030 WIDTH=8, a=0x3C, b=0x05, cin=0, start pulse -> busy high for 8 cycles, then done pulse, s=0x41, cout=0, overflow=0.
REQ-031 WIDTH=8, a=0xFF, b=0xFF, cin=1 -> s=0xFF, cout=1, overflow=0; a=0x7F, b=0x01, cin=0 -> s=0x80, overflow=1.
REQ-032 Start held high across two operations (0x10+0x20, then 0x01+0x01) -> done pulses 9 cycles apart, s=0x30 then s=0x02, no IDLE cycle between them.
REQ-033 rst_n pulsed low during the 4th RUN cycle -> outputs zero at once, no done; next op 0x02+0x03 -> s=0x05 after 8 cycles.
REQ-034 Start and operand changes asserted during RUN -> ignored; result matches operands latched at acceptance.
REQ-035 With SOMADOR_SUB_EN: sub=1, a=0x05, b=0x07 -> s=0xFE, cout=0; sub=1, a=0x07, b=0x05 -> s=0x02, cout=1.
